// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state type, zero-register index
// and the default multiplier latency.
package cpu_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } ctrl_state_t;

  localparam logic [4:0]  XZR_REG         = 5'd31;
  localparam int unsigned MUL_LAT_DEFAULT = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID
// instruction reads. XZR is never a real dependency.
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic       i_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rn,
  input  logic [4:0] i_id_rm,
  input  logic       i_id_uses_rm,
  output logic       o_hazard
);

  logic w_rd_live;
  logic w_rn_match;
  logic w_rm_match;

  assign w_rd_live  = i_mem_read && (i_ex_rd != XZR_REG);
  assign w_rn_match = (i_ex_rd == i_id_rn);
  assign w_rm_match = (i_ex_rd == i_id_rm) && i_id_uses_rm;
  assign o_hazard   = w_rd_live && (w_rn_match || w_rm_match);

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: multi-cycle MUL stall, taken-branch flush
// and load-use stall. Define STALL_PERF_CNT_EN to add stall/flush counters.
module stall_flush_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRd,
  input  logic [4:0] IF_ID_RegisterRn,
  input  logic [4:0] IF_ID_RegisterRm,
  input  logic       IF_ID_UsesRm,
  input  logic       EX_MulIssue,
  input  logic       EX_BrTaken,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       EX_MEM_Bubble,
  output logic       MulBusy,
  output logic       MulDone
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

  ctrl_state_t r_state;
  logic [3:0]  r_cnt;
  logic        w_load_use;
  logic        w_idle;
  logic        w_mul_stall;
  logic        w_br_flush;

  load_use_detect u_load_use_detect (
    .i_mem_read   (ID_EX_MemRead),
    .i_ex_rd      (ID_EX_RegisterRd),
    .i_id_rn      (IF_ID_RegisterRn),
    .i_id_rm      (IF_ID_RegisterRm),
    .i_id_uses_rm (IF_ID_UsesRm),
    .o_hazard     (w_load_use)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (EX_MulIssue) begin
            r_state <= MUL_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        MUL_BUSY: begin
          if (r_cnt == 4'd0) r_state <= IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Issue cycle counts as the first busy cycle; branches are only honoured in IDLE.
  assign w_idle      = (r_state == IDLE);
  assign MulBusy     = (w_idle && EX_MulIssue) || (r_state == MUL_BUSY);
  assign MulDone     = (r_state == MUL_BUSY) && (r_cnt == 4'd0);
  assign w_mul_stall = MulBusy && !MulDone;
  assign w_br_flush  = w_idle && EX_BrTaken;

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    if (w_mul_stall) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Bubble = 1'b1;
    end else if (w_br_flush) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (w_load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (IF_ID_Flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl (MUL_LAT=4); perf counters are checked
// when STALL_PERF_CNT_EN is defined.
module tb_stall_flush_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRd;
  logic [4:0] IF_ID_RegisterRn;
  logic [4:0] IF_ID_RegisterRm;
  logic       IF_ID_UsesRm;
  logic       EX_MulIssue;
  logic       EX_BrTaken;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       ID_EX_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Bubble;
  logic       EX_MEM_Bubble;
  logic       MulBusy;
  logic       MulDone;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  // {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulBusy, MulDone}
  localparam logic [7:0] NORM = 8'b1110_0000;
  localparam logic [7:0] LU   = 8'b0010_1000;
  localparam logic [7:0] BR   = 8'b1111_1000;
  localparam logic [7:0] MULS = 8'b0000_0110;
  localparam logic [7:0] MULD = 8'b1110_0011;

  logic [7:0] w_obs;
  assign w_obs = {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush,
                  ID_EX_Bubble, EX_MEM_Bubble, MulBusy, MulDone};

  stall_flush_ctrl #(.MUL_LAT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRd (ID_EX_RegisterRd),
    .IF_ID_RegisterRn (IF_ID_RegisterRn),
    .IF_ID_RegisterRm (IF_ID_RegisterRm),
    .IF_ID_UsesRm     (IF_ID_UsesRm),
    .EX_MulIssue      (EX_MulIssue),
    .EX_BrTaken       (EX_BrTaken),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .ID_EX_Write      (ID_EX_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .EX_MEM_Bubble    (EX_MEM_Bubble),
    .MulBusy          (MulBusy),
    .MulDone          (MulDone)
`ifdef STALL_PERF_CNT_EN
    ,
    .StallCnt         (StallCnt),
    .FlushCnt         (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then check the combinational outputs.
  task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [4:0] rm, input logic urm, input logic mi,
                     input logic bt, input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRd = rd;
    IF_ID_RegisterRn = rn;
    IF_ID_RegisterRm = rm;
    IF_ID_UsesRm     = urm;
    EX_MulIssue      = mi;
    EX_BrTaken       = bt;
    #2;
    check_eq(tag, {8'h00, w_obs}, {8'h00, exp});
  endtask

  task automatic idle_cyc(input string tag);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tag, NORM);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n          = 1'b1;
    ID_EX_MemRead    = 1'b0;
    ID_EX_RegisterRd = 5'd0;
    IF_ID_RegisterRn = 5'd0;
    IF_ID_RegisterRm = 5'd0;
    IF_ID_UsesRm     = 1'b0;
    EX_MulIssue      = 1'b0;
    EX_BrTaken       = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_eq("reset_outputs", {8'h00, w_obs}, {8'h00, NORM});
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;

    idle_cyc("idle");
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, "loaduse_rn", LU);
    idle_cyc("after_loaduse");
    cyc(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, "loaduse_rm", LU);
    cyc(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, "rm_not_used", NORM);
    cyc(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, "xzr_no_stall", NORM);
    cyc(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, "not_load", NORM);
    cyc(1'b1, 5'd30, 5'd30, 5'd0, 1'b0, 1'b0, 1'b0, "loaduse_r30", LU);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "branch", BR);
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, "branch_over_loaduse", BR);

    // MUL: issue together with a branch, then stray issue/branch/load-use while busy.
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, "mul_c1", MULS);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, "mul_c2", MULS);
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, "mul_c3", MULS);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, "mul_c4_done", MULD);
    idle_cyc("mul_after");
    idle_cyc("mul_after2");

    // Reset asserted in MUL cycle 2 abandons the MUL.
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "mulrst_c1", MULS);
    @(posedge clk);
    #1 EX_MulIssue = 1'b0;
    check_eq("mulrst_c2_busy", {15'h0, MulBusy}, 16'h0001);
    reset_n = 1'b0;
    #1 check_eq("mulrst_async", {8'h00, w_obs}, {8'h00, NORM});
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) idle_cyc("mulrst_no_done");

`ifdef STALL_PERF_CNT_EN
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_eq("perf_reset_stall", StallCnt, 16'd0);
    check_eq("perf_reset_flush", FlushCnt, 16'd0);
    reset_n = 1'b1;
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, "perf_lu1", LU);
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, "perf_lu2", LU);
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, "perf_lu3", LU);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "perf_br", BR);
    idle_cyc("perf_idle");
    check_eq("perf_stallcnt", StallCnt, 16'd3);
    check_eq("perf_flushcnt", FlushCnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 4, meaning total EX-stage cycles of a MUL; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ID_EX_MemRead, input, 1, the instruction in EX is a load.
REQ-005 The block SHALL have port ID_EX_RegisterRd, input, 5, the EX destination register.
REQ-006 The block SHALL have port IF_ID_RegisterRn, input, 5, the ID source register Rn.
REQ-007 The block SHALL have port IF_ID_RegisterRm, input, 5, the ID source register Rm.
REQ-008 The block SHALL have port IF_ID_UsesRm, input, 1, the ID instruction reads Rm.
REQ-009 The block SHALL have port EX_MulIssue, input, 1, a MUL enters EX this cycle.
REQ-010 The block SHALL have port EX_BrTaken, input, 1, the branch in EX resolves taken.
REQ-011 The block SHALL have outputs PCWrite, IF_ID_Write and ID_EX_Write, each 1 bit, pipeline-register enables.
REQ-012 The block SHALL have outputs IF_ID_Flush, ID_EX_Bubble and EX_MEM_Bubble, each 1 bit, which zero the control fields of the named register.
REQ-013 The block SHALL have outputs MulBusy (1 bit, MUL in progress) and MulDone (1 bit, final MUL cycle).

Function
REQ-014 The block SHALL implement the states IDLE and MUL_BUSY, plus a 4-bit down-counter cnt.
REQ-015 In IDLE with EX_MulIssue=1, the block SHALL load cnt=MUL_LAT-2 and go to MUL_BUSY on the next edge.
REQ-016 In MUL_BUSY, the block SHALL decrement cnt each cycle and return to IDLE on the edge where cnt==0.
REQ-017 The block SHALL assert MulBusy in the issue cycle and in every MUL_BUSY cycle, so that the total is MUL_LAT cycles.
REQ-018 The block SHALL assert MulDone only in the last MulBusy cycle, which is MUL_BUSY with cnt==0.
REQ-019 While MulBusy is high and MulDone is low, the block SHALL drive PCWrite=0, IF_ID_Write=0, ID_EX_Write=0 and EX_MEM_Bubble=1.
REQ-020 The block SHALL detect a load-use hazard when ID_EX_MemRead=1, ID_EX_RegisterRd!=31, and Rd equals IF_ID_RegisterRn, or Rd equals IF_ID_RegisterRm with IF_ID_UsesRm=1.
REQ-021 On a load-use hazard outside a MUL stall, the block SHALL drive PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 for exactly that cycle, giving a 1-cycle stall.
REQ-022 On EX_BrTaken=1, the block SHALL drive IF_ID_Flush=1 and ID_EX_Bubble=1, and SHALL keep PCWrite=1 so the target loads.
REQ-023 Priority SHALL be MUL stall > branch flush > load-use; a branch suppresses a simultaneous load-use stall.
REQ-024 EX_MulIssue and EX_BrTaken inputs arriving while in MUL_BUSY SHALL be ignored.
REQ-025 With no hazard, the block SHALL drive all enables to 1 and all flush and bubble outputs to 0.
REQ-026 Outputs SHALL be combinational from the state, cnt and the inputs, with no added latency.

Reset
REQ-027 When reset_n=0, the block SHALL immediately force state=IDLE and cnt=0, independent of clk.
REQ-028 With reset asserted and all inputs at 0, the block SHALL drive PCWrite=1, IF_ID_Write=1, ID_EX_Write=1 and all other outputs 0.
REQ-029 A reset asserted mid-MUL SHALL abandon the MUL, and the block SHALL not assert MulDone afterward.

Configuration
REQ-030 With STALL_PERF_CNT_EN defined, the block SHALL add outputs StallCnt[15:0] and FlushCnt[15:0].
REQ-031 StallCnt SHALL count cycles with PCWrite=0, and FlushCnt SHALL count cycles with IF_ID_Flush=1.
REQ-032 Both counters SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-033 Without STALL_PERF_CNT_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package cpu_ctrl_pkg SHALL hold the state enum typedef, the constant XZR_REG=5'd31 and the default MUL_LAT.
REQ-035 The load-use comparator SHALL be a sub-module load_use_detect; the rest SHALL remain in stall_flush_ctrl.

Verification
REQ-036 Load-use: ID_EX_MemRead=1, Rd=5, IF_ID_Rn=5 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then normal.
REQ-037 XZR: ID_EX_MemRead=1, Rd=31, IF_ID_Rn=31 -> no stall.
REQ-038 MUL with MUL_LAT=4: EX_MulIssue pulse -> MulBusy for 4 cycles, MulDone on the 4th only, stall on cycles 1-3.
REQ-039 Branch plus load-use in the same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
REQ-040 MUL reset: reset_n low during MUL cycle 2 -> all outputs at reset values immediately, and no MulDone after release.
REQ-041 STALL_PERF_CNT_EN: 3 stall cycles plus 1 flush -> StallCnt=3, FlushCnt=1.
